// File: rtl/setup_move_sequencer.sv
// rtl/setup_move_sequencer.sv - plays stored face-turn setup sequences on six stepper drivers (optional RBOT_SETTLE_EN adds a settle wait)
module setup_move_sequencer #(
    parameter int STEPS_PER_QUARTER = 50,
    parameter int STEP_PERIOD       = 65000,
    parameter int GAP_CYCLES        = 6500,
    parameter int SETTLE_CYCLES     = 650000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_setup_moves,
    output logic       done_turning,
    output logic       busy,
    output logic [5:0] obs_index,
    output logic [5:0] motor_step,
    output logic [5:0] motor_dir
);
    localparam int HALF    = STEP_PERIOD / 2;
    localparam int CNT_A   = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
    localparam int CNT_MAX = (CNT_A > SETTLE_CYCLES) ? CNT_A : SETTLE_CYCLES;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(2 * STEPS_PER_QUARTER + 1);

    // Move word: {face[2:0], turn[1:0]}; turn 1 = CW, 3 = CCW, 2 = half.
    localparam logic [4:0] M_U  = 5'd1,  M_UI = 5'd3;
    localparam logic [4:0] M_L  = 5'd5,  M_LI = 5'd7,  M_L2 = 5'd6;
    localparam logic [4:0] M_F  = 5'd9,  M_FI = 5'd11, M_F2 = 5'd10;
    localparam logic [4:0] M_R  = 5'd13, M_RI = 5'd15, M_R2 = 5'd14;
    localparam logic [4:0] M_B  = 5'd17, M_BI = 5'd19, M_B2 = 5'd18;
    localparam logic [4:0] M_END = 5'b11100;

    // Per group: SETUP string then UNDO string, each END-terminated; the
    // single "U" string used for non-first positions sits at the end.
    localparam logic [4:0] ROM [0:101] = '{
        M_END, M_END,
        M_F,  M_BI, M_END, M_B,  M_FI, M_END,
        M_LI, M_R,  M_END, M_RI, M_L,  M_END,
        M_FI, M_B,  M_END, M_BI, M_F,  M_END,
        M_L,  M_RI, M_END, M_R,  M_LI, M_END,
        M_L2, M_R2, M_END, M_L2, M_R2, M_END,
        M_END, M_END,
        M_F,  M_BI, M_L,  M_U,  M_F,  M_BI, M_END,
        M_B,  M_FI, M_UI, M_LI, M_B,  M_FI, M_END,
        M_LI, M_R,  M_F,  M_UI, M_LI, M_R,  M_END,
        M_RI, M_L,  M_U,  M_FI, M_RI, M_L,  M_END,
        M_FI, M_B,  M_R,  M_U,  M_FI, M_B,  M_END,
        M_BI, M_F,  M_UI, M_RI, M_BI, M_F,  M_END,
        M_L,  M_RI, M_BI, M_U,  M_L,  M_RI, M_END,
        M_R,  M_LI, M_UI, M_B,  M_R,  M_LI, M_END,
        M_R2, M_L2, M_F2, M_B2, M_END,
        M_B2, M_F2, M_L2, M_R2, M_END,
        M_U,  M_END
    };
    localparam logic [6:0] SETUP_BASE [0:11] = '{7'd0, 7'd2, 7'd8, 7'd14, 7'd20, 7'd26,
                                                 7'd32, 7'd34, 7'd48, 7'd62, 7'd76, 7'd90};
    localparam logic [6:0] UNDO_BASE  [0:11] = '{7'd1, 7'd5, 7'd11, 7'd17, 7'd23, 7'd29,
                                                 7'd33, 7'd41, 7'd55, 7'd69, 7'd83, 7'd95};
    localparam logic [6:0] U_BASE = 7'd100;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP_HI, S_STEP_LO, S_GAP,
`ifdef RBOT_SETTLE_EN
        S_SETTLE,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    ptr_q, ptr_d;
    logic          undo_q, undo_d;
    logic [5:0]    face_q, face_d;
    logic [PW-1:0] pulses_q, pulses_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    dir_q, dir_d;
    logic [5:0]    obs_q, obs_d;

    logic [4:0] rom_word;
    logic [5:0] rom_mask;
    logic [3:0] grp;
    logic [5:0] obs_inc;

    assign rom_word = ROM[ptr_q];
    assign rom_mask = 6'b000001 << rom_word[4:2];
    assign grp      = obs_q[5:2];
    assign obs_inc  = (obs_q == 6'd47) ? 6'd0 : obs_q + 6'd1;

    assign obs_index = obs_q;
    assign motor_dir = dir_q;

    // State and datapath registers; reset abandons any move in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            undo_q   <= 1'b0;
            face_q   <= '0;
            pulses_q <= '0;
            timer_q  <= '0;
            dir_q    <= '0;
            obs_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            undo_q   <= undo_d;
            face_q   <= face_d;
            pulses_q <= pulses_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            obs_q    <= obs_d;
        end
    end

    // Next-state, datapath updates and output decode.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        undo_d       = undo_q;
        face_d       = face_q;
        pulses_d     = pulses_q;
        timer_d      = timer_q;
        dir_d        = dir_q;
        obs_d        = obs_q;
        motor_step   = 6'd0;
        busy         = 1'b1;
        done_turning = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (send_setup_moves) begin
                    state_d = S_LOAD;
                    if (obs_q[1:0] != 2'd0) begin
                        undo_d = 1'b0;
                        ptr_d  = U_BASE;
                    end else if (grp != 4'd0) begin
                        undo_d = 1'b1;
                        ptr_d  = UNDO_BASE[grp - 4'd1];
                    end else begin
                        undo_d = 1'b0;
                        ptr_d  = SETUP_BASE[grp];
                    end
                end
            end
            S_LOAD: begin
                if (rom_word[4:2] == 3'd7) begin
                    if (undo_q) begin
                        undo_d = 1'b0;
                        ptr_d  = SETUP_BASE[grp];
                    end else begin
`ifdef RBOT_SETTLE_EN
                        state_d = S_SETTLE;
                        timer_d = TW'(SETTLE_CYCLES - 1);
`else
                        state_d = S_DONE;
                        obs_d   = obs_inc;
`endif
                    end
                end else begin
                    face_d   = rom_mask;
                    dir_d    = (rom_word[1:0] == 2'd3) ? (dir_q & ~rom_mask) : (dir_q | rom_mask);
                    pulses_d = (rom_word[1:0] == 2'd2) ? PW'(2 * STEPS_PER_QUARTER)
                                                       : PW'(STEPS_PER_QUARTER);
                    timer_d  = TW'(HALF - 1);
                    state_d  = S_STEP_HI;
                end
            end
            S_STEP_HI: begin
                motor_step = face_q;
                if (timer_q == '0) begin
                    timer_d = TW'(HALF - 1);
                    state_d = S_STEP_LO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STEP_LO: begin
                if (timer_q == '0) begin
                    pulses_d = pulses_q - 1'b1;
                    if (pulses_q == PW'(1)) begin
                        timer_d = TW'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end else begin
                        timer_d = TW'(HALF - 1);
                        state_d = S_STEP_HI;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    ptr_d   = ptr_q + 7'd1;
                    state_d = S_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef RBOT_SETTLE_EN
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_DONE;
                    obs_d   = obs_inc;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            S_DONE: begin
                busy         = 1'b0;
                done_turning = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_setup_move_sequencer.sv
// tb/tb_setup_move_sequencer.sv - randomized self-checking bench for setup_move_sequencer
module tb_setup_move_sequencer;
    localparam int SPQ    = 2;
    localparam int SP     = 4;
    localparam int GAP    = 3;
    localparam int SETTLE = 5;
    localparam int HALF   = SP / 2;

    typedef struct packed {
        logic [5:0] step;
        logic [5:0] dir;
        logic [5:0] obs;
        logic       busy;
        logic       done;
    } cyc_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       send_setup_moves;
    logic       done_turning;
    logic       busy;
    logic [5:0] obs_index;
    logic [5:0] motor_step;
    logic [5:0] motor_dir;

    int tests = 0;
    int fails = 0;

    cyc_t       exp_q[$];
    logic [5:0] dir_m;
    int         obs_m;

    string setup_s [12] = '{"", "F B'", "L' R", "F' B", "L R'", "L2 R2", "",
                            "F B' L U F B'", "L' R F U' L' R", "F' B R U F' B",
                            "L R' B' U L R'", "R2 L2 F2 B2"};
    string undo_s  [12] = '{"", "B F'", "R' L", "B' F", "R L'", "L2 R2", "",
                            "B F' U' L' B F'", "R' L U F' R' L", "B' F U' R' B' F",
                            "R L' U' B R L'", "B2 F2 L2 R2"};

    setup_move_sequencer #(
        .STEPS_PER_QUARTER(SPQ),
        .STEP_PERIOD(SP),
        .GAP_CYCLES(GAP),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .send_setup_moves(send_setup_moves),
        .done_turning(done_turning),
        .busy(busy),
        .obs_index(obs_index),
        .motor_step(motor_step),
        .motor_dir(motor_dir)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic int face_of(input byte c);
        case (c)
            "U": return 0;
            "L": return 1;
            "F": return 2;
            "R": return 3;
            "B": return 4;
            default: return 5;
        endcase
    endfunction

    task automatic push_cyc(input logic [5:0] step, input logic b, input logic d, input int obs);
        cyc_t c;
        c.step = step;
        c.dir  = dir_m;
        c.obs  = 6'(obs);
        c.busy = b;
        c.done = d;
        exp_q.push_back(c);
    endtask

    // One move: a fetch cycle, the pulse train, then the idle gap.
    task automatic add_move(input int f, input int n, input bit cw);
        push_cyc(6'd0, 1'b1, 1'b0, obs_m);
        dir_m[f] = cw;
        repeat (n) begin
            repeat (HALF) push_cyc(6'(1 << f), 1'b1, 1'b0, obs_m);
            repeat (HALF) push_cyc(6'd0, 1'b1, 1'b0, obs_m);
        end
        repeat (GAP) push_cyc(6'd0, 1'b1, 1'b0, obs_m);
    endtask

    // Parse move notation ("F B' L2") and append the END fetch cycle.
    task automatic add_string(input string s);
        int  i;
        int  f;
        int  n;
        bit  cw;
        byte c;
        i = 0;
        while (i < s.len()) begin
            c = s[i];
            if (c == " ") begin
                i++;
                continue;
            end
            f  = face_of(c);
            i++;
            n  = SPQ;
            cw = 1'b1;
            if (i < s.len()) begin
                c = s[i];
                if (c == "'") begin
                    cw = 1'b0;
                    i++;
                end else if (c == "2") begin
                    n = 2 * SPQ;
                    i++;
                end
            end
            add_move(f, n, cw);
        end
        push_cyc(6'd0, 1'b1, 1'b0, obs_m);
    endtask

    task automatic run_req(input bit do_rst);
        int   k;
        int   g;
        int   p;
        int   n;
        int   inj;
        int   rst_at;
        int   lat;
        int   hi_idx[$];
        cyc_t e;
        k      = obs_m;
        g      = k / 4;
        p      = k % 4;
        rst_at = -1;
        lat    = -1;
        exp_q.delete();
        if (p != 0) begin
            add_string("U");
        end else begin
            if (g > 0) add_string(undo_s[g-1]);
            add_string(setup_s[g]);
        end
`ifdef RBOT_SETTLE_EN
        repeat (SETTLE) push_cyc(6'd0, 1'b1, 1'b0, obs_m);
`endif
        push_cyc(6'd0, 1'b0, 1'b1, (k + 1) % 48);
        n   = exp_q.size();
        inj = $urandom_range(n - 2, 0);
        if (do_rst) begin
            for (int j = 0; j < n; j++)
                if (exp_q[j].step != 6'd0) hi_idx.push_back(j);
            if (hi_idx.size() > 0) rst_at = hi_idx[$urandom_range(hi_idx.size() - 1, 0)];
        end

        send_setup_moves = 1'b1;
        @(negedge clock);
        send_setup_moves = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = exp_q[i];
            check($sformatf("k%0d/c%0d step", k, i), 32'(motor_step), 32'(e.step));
            check($sformatf("k%0d/c%0d dir", k, i), 32'(motor_dir), 32'(e.dir));
            check($sformatf("k%0d/c%0d busy", k, i), 32'(busy), 32'(e.busy));
            check($sformatf("k%0d/c%0d done", k, i), 32'(done_turning), 32'(e.done));
            check($sformatf("k%0d/c%0d obs", k, i), 32'(obs_index), 32'(e.obs));
            if (done_turning === 1'b1 && lat < 0) lat = i + 1;
            if (i == inj) send_setup_moves = 1'b1;
            if (do_rst && i == rst_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset            = 1'b0;
                send_setup_moves = 1'b0;
                check("rst_mid step", 32'(motor_step), 32'd0);
                check("rst_mid busy", 32'(busy), 32'd0);
                check("rst_mid obs", 32'(obs_index), 32'd0);
                check("rst_mid dir", 32'(motor_dir), 32'd0);
                check("rst_mid done", 32'(done_turning), 32'd0);
                obs_m = 0;
                dir_m = 6'd0;
                return;
            end
            @(negedge clock);
            send_setup_moves = 1'b0;
        end
        check($sformatf("k%0d latency", k), 32'(lat), 32'(n));
        obs_m = (k + 1) % 48;
        repeat ($urandom_range(3, 1)) begin
            check($sformatf("k%0d idle busy", k), 32'(busy), 32'd0);
            check($sformatf("k%0d idle step", k), 32'(motor_step), 32'd0);
            check($sformatf("k%0d idle done", k), 32'(done_turning), 32'd0);
            @(negedge clock);
        end
    endtask

    initial begin
        reset            = 1'b1;
        send_setup_moves = 1'b0;
        dir_m            = 6'd0;
        obs_m            = 0;
        repeat (3) @(negedge clock);
        check("reset done", 32'(done_turning), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset obs", 32'(obs_index), 32'd0);
        check("reset step", 32'(motor_step), 32'd0);
        check("reset dir", 32'(motor_dir), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int r = 0; r < 49; r++) run_req(1'b0);
        run_req(1'b1);
        run_req(1'b0);
        run_req(1'b0);
        run_req(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
